// File: rtl/frame_scheduler.sv
// frame_scheduler
// Sequences the double-buffered frame pipeline in the GPU clock domain:
// clears the back buffer, pulses the renderer start, muxes the frame-buffer
// write port between the clear engine and the renderer, then swaps buffers
// on the next vertical sync once the renderer reports completion.
//
// Ports:
//   gpu_clk_150            GPU clock, rising edge
//   reset                  synchronous active-low reset
//   vga_vs                 VGA vertical sync (asynchronous, synchronized here)
//   gpu_done               renderer level: frame finished
//   gpu_x/gpu_y/gpu_data   renderer write coordinate and pixel
//   gpu_we                 renderer write request
//   gpu_ready              renderer writes accepted this cycle
//   gpu_start              one-cycle pulse: begin rendering
//   fb_x/fb_y/fb_data      registered frame-buffer write coordinate and pixel
//   fb_we                  registered frame-buffer write enable
//   write_buffer           index of the back buffer being written
//   swap_count             swaps performed (wrapping)
//   late_frames            vsync edges with no frame ready (saturating)
//   wr_dropped             sticky: renderer wrote while not ready
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CLEAR    | clear engine owns the write port, one pixel per cycle
// START    | single-cycle renderer start pulse, disarm gpu_done
// RENDER   | renderer owns the write port, wait for a fresh gpu_done
// WAIT_VS  | frame complete, swap buffers on next vsync rise
module frame_scheduler #(
  parameter int         FRAME_W     = 320,
  parameter int         FRAME_H     = 240,
  parameter logic [3:0] CLEAR_COLOR = 4'h0
) (
  input  logic        gpu_clk_150,
  input  logic        reset,
  input  logic        vga_vs,
  input  logic        gpu_done,
  input  logic [9:0]  gpu_x,
  input  logic [9:0]  gpu_y,
  input  logic [3:0]  gpu_data,
  input  logic        gpu_we,
  output logic        gpu_ready,
  output logic        gpu_start,
  output logic [9:0]  fb_x,
  output logic [9:0]  fb_y,
  output logic [3:0]  fb_data,
  output logic        fb_we,
  output logic        write_buffer,
  output logic [15:0] swap_count,
  output logic [7:0]  late_frames,
  output logic        wr_dropped
);

  localparam logic [9:0] LAST_X = 10'(FRAME_W - 1);
  localparam logic [9:0] LAST_Y = 10'(FRAME_H - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_START,
    ST_RENDER,
    ST_WAIT_VS
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] cx, cy;
  logic       armed;
  logic       vs_meta, vs_sync, vs_prev;
  logic       vs_rise;
  logic       clear_last;

  assign vs_rise    = vs_sync & ~vs_prev;
  assign clear_last = (cx == LAST_X) && (cy == LAST_Y);

  always_ff @(posedge gpu_clk_150) begin
    if (!reset) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gpu_ready = 1'b0;
    gpu_start = 1'b0;
    case (state)
      ST_CLEAR:   if (clear_last) state_nxt = ST_START;
      ST_START: begin
        gpu_start = 1'b1;
        state_nxt = ST_RENDER;
      end
      ST_RENDER: begin
        gpu_ready = 1'b1;
        // armed holds off a gpu_done left high from the previous frame
        if (armed && gpu_done) state_nxt = ST_WAIT_VS;
      end
      ST_WAIT_VS: if (vs_rise) state_nxt = ST_CLEAR;
      default:    state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge gpu_clk_150) begin
    if (!reset) begin
      vs_meta      <= 1'b0;
      vs_sync      <= 1'b0;
      vs_prev      <= 1'b0;
      cx           <= '0;
      cy           <= '0;
      armed        <= 1'b0;
      fb_we        <= 1'b0;
      fb_x         <= '0;
      fb_y         <= '0;
      fb_data      <= '0;
      write_buffer <= 1'b0;
      swap_count   <= '0;
      late_frames  <= '0;
      wr_dropped   <= 1'b0;
    end else begin
      vs_meta <= vga_vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      fb_we   <= 1'b0;

      case (state)
        ST_CLEAR: begin
          fb_we   <= 1'b1;
          fb_x    <= cx;
          fb_y    <= cy;
          fb_data <= CLEAR_COLOR;
          if (cx == LAST_X) begin
            cx <= '0;
            cy <= (cy == LAST_Y) ? 10'd0 : cy + 10'd1;
          end else begin
            cx <= cx + 10'd1;
          end
        end
        ST_START: armed <= 1'b0;
        ST_RENDER: begin
          if (!gpu_done) armed <= 1'b1;
          // coordinates hold when the renderer is idle
          if (gpu_we) begin
            fb_we   <= 1'b1;
            fb_x    <= gpu_x;
            fb_y    <= gpu_y;
            fb_data <= gpu_data;
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise) begin
            write_buffer <= ~write_buffer;
            swap_count   <= swap_count + 16'd1;
          end
        end
        default: ;
      endcase

      // any vsync outside WAIT_VS means the display repeats a frame
      if (vs_rise && (state != ST_WAIT_VS) && (late_frames != 8'hFF))
        late_frames <= late_frames + 8'd1;

      if (gpu_we && !gpu_ready) wr_dropped <= 1'b1;
    end
  end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Single-clock controller in the GPU clock domain that sequences the double-buffered frame pipeline.
- Clears the back buffer, issues the renderer start pulse, and arbitrates the frame-buffer write port between the clear engine and the renderer.
- Waits for renderer completion, then requests the buffer swap on the next vertical sync.
- Sits between the rasterizer and frame_director; drives frame_director's gpu_x/gpu_y/gpu_data/gpu_we and owns buffer selection.

Parameters:
- FRAME_W, 320, pixels per line written by the clear engine.
- FRAME_H, 240, lines per frame written by the clear engine.
- CLEAR_COLOR, 4'h0, pixel value written during clear.

Ports:
- gpu_clk_150  in  1  GPU clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- vga_vs  in  1  VGA vertical sync, asynchronous to gpu_clk_150.
- gpu_done  in  1  renderer level: current frame finished.
- gpu_x, gpu_y  in  10 each  renderer write coordinate.
- gpu_data  in  4  renderer pixel value.
- gpu_we  in  1  renderer write request.
- gpu_ready  out  1  renderer writes are accepted this cycle.
- gpu_start  out  1  one-cycle pulse: begin rendering a frame.
- fb_x, fb_y  out  10 each  frame-buffer write coordinate.
- fb_data  out  4  frame-buffer write data.
- fb_we  out  1  frame-buffer write enable.
- write_buffer  out  1  index of the back buffer currently being written.
- swap_count  out  16  swaps performed; wraps at 2^16.
- late_frames  out  8  vsync edges with no frame ready; saturates at 255.
- wr_dropped  out  1  sticky: gpu_we was asserted while gpu_ready=0.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=CLEAR, clear cursor=(0,0).
  - write_buffer=0, swap_count=0, late_frames=0, wr_dropped=0.
  - gpu_start=0, fb_we=0, fb_x/fb_y/fb_data=0, sync flops=0.
  - Reset mid-operation aborts any clear or render immediately; no swap is issued.
- vsync sync: 2-flop synchronizer plus edge register. vs_rise is a one-cycle pulse on a synchronized 0->1 transition, 3 clocks after the vga_vs edge at worst.
- Write port: registered, 1-cycle latency. fb_* at cycle n+1 reflect the selected source at cycle n. When no source is writing, fb_we=0 and fb_x/fb_y/fb_data hold their values.
- States:
  - CLEAR:
    - Each cycle: fb_we<=1, fb_x<=cx, fb_y<=cy, fb_data<=CLEAR_COLOR.
    - Cursor steps in raster order: cx increments; at FRAME_W-1, cx wraps to 0 and cy increments.
    - After the write of (FRAME_W-1, FRAME_H-1): cursor resets to (0,0) and state goes to START.
    - Duration: exactly FRAME_W*FRAME_H cycles. gpu_ready=0.
  - START: gpu_start=1 for this single cycle, armed<=0, then RENDER. gpu_ready=0.
  - RENDER:
    - gpu_ready=1; fb_we<=gpu_we, fb_x/fb_y/fb_data<=gpu inputs.
    - armed<=1 on the first cycle gpu_done=0.
    - When armed=1 and gpu_done=1, go to WAIT_VS. A write presented in that same cycle is still accepted.
    - gpu_done held high from the previous frame is therefore ignored until it has been seen low.
  - WAIT_VS:
    - gpu_ready=0, fb_we<=0.
    - On vs_rise: write_buffer<=~write_buffer, swap_count<=swap_count+1, state<=CLEAR.
- gpu_start is a combinational decode of state==START and is glitch-free: state is registered.
- late_frames increments (saturating) on vs_rise while in CLEAR, START or RENDER. No swap occurs then; the display repeats its frame.
- wr_dropped sets when gpu_we=1 and gpu_ready=0. It clears only on reset.
- Simultaneous vs_rise and gpu_done in RENDER:
  - The transition to WAIT_VS happens and late_frames increments.
  - The swap waits for the next vs_rise.
- Widths: cx/cy are 10 bits; FRAME_W and FRAME_H must be ≤1024.

Test Plan:
- FRAME_W=4, FRAME_H=2, release reset -> fb_we=1 for exactly 8 consecutive cycles covering (0,0)..(3,0),(0,1)..(3,1) with fb_data=0; then gpu_start high exactly 1 cycle; write_buffer=0.
- In RENDER, drive gpu_we=1, (5,7), data 4'hA -> next cycle fb_we=1, fb_x=5, fb_y=7, fb_data=A; gpu_ready=1.
- Hold gpu_done=1 through START, then drop it for 1 cycle, then raise it -> WAIT_VS entered only after the rise; vga_vs pulse -> within 3 clocks write_buffer=1, swap_count=1, clear restarts at (0,0).
- vga_vs rising during RENDER with gpu_done=0, three times -> late_frames=3, write_buffer unchanged; 300 edges -> late_frames=255.
- gpu_we=1 during CLEAR -> fb_data stays CLEAR_COLOR, wr_dropped=1 and remains 1 until reset.
- reset=0 for one clock mid-RENDER after one swap -> next cycle state CLEAR at (0,0), write_buffer=0, swap_count=0, gpu_ready=0.
